// File: rtl/imem_encoder.sv
// imem_encoder: packs decoded MIPS fields into 32-bit words and streams them into instruction memory.
// Three-state loader: accept a field set, hold the write until acked, stop on last or at the top word.
module imem_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    input  logic              last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              done,
    output logic              full,
    output logic              err_illegal,
    output logic [ADDR_W:0]   count
);
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
    state_t state, state_nx;
    logic r_type, i_type, j_type, legal, accept, ack, at_max, clear, last_q, stop;
    logic [31:0] enc;
    always_comb begin
        r_type = opcode == 6'h00;
        i_type = opcode == 6'h08 || opcode == 6'h23 || opcode == 6'h2b || opcode == 6'h04;
        j_type = opcode == 6'h02;
        legal  = r_type | i_type | j_type;
        enc    = r_type ? {opcode, rs, rt, rd, shamt, funct}
               : i_type ? {opcode, rs, rt, imm}
               : {opcode, target};
        in_ready = state == IDLE;
        accept   = in_valid & in_ready & ~start;
        ack      = state == WRITE & mem_ack;
        at_max   = &mem_addr;
        clear    = start & state != WRITE;
        stop     = last_q | at_max;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept & legal ? WRITE : IDLE;
            WRITE:   state_nx = ack ? (stop ? DONE : IDLE) : WRITE;
            DONE:    state_nx = start ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            last_q      <= 1'b0;
            done        <= 1'b0;
            full        <= 1'b0;
            err_illegal <= 1'b0;
            count       <= '0;
        end else begin
            if (clear) begin
                mem_addr    <= '0;
                count       <= '0;
                done        <= 1'b0;
                full        <= 1'b0;
                err_illegal <= 1'b0;
            end
            if (accept & legal) begin
                mem_wdata <= enc;
                last_q    <= last;
                mem_we    <= 1'b1;
            end
            if (accept & ~legal) err_illegal <= 1'b1;
            // The top word is terminal: hold the address there rather than wrapping.
            if (ack) begin
                mem_we   <= 1'b0;
                count    <= count + (ADDR_W+1)'(1);
                mem_addr <= at_max ? mem_addr : mem_addr + ADDR_W'(1);
                full     <= at_max;
                done     <= stop;
            end
        end
    end
endmodule

// File: tb/tb_imem_encoder.sv
// tb_imem_encoder: table vectors, directed corner sequences and a randomized run against a field-packing model.
module tb_imem_encoder;
    logic        clk = 1'b0;
    logic        reset, start, in_valid, last, mem_ack;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic        in_ready, mem_we, done, full, err_illegal;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  count;
    logic        in_ready2, mem_we2, done2, full2, err2;
    logic [1:0]  mem_addr2;
    logic [31:0] mem_wdata2;
    logic [2:0]  count2;

    imem_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm(imm), .target(target), .last(last), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .done(done), .full(full),
        .err_illegal(err_illegal), .count(count)
    );
    imem_encoder #(.ADDR_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm(imm), .target(target), .last(last), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .mem_ack(mem_ack), .done(done2), .full(full2),
        .err_illegal(err2), .count(count2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic        last;
        logic        legal;
        logic [31:0] word;
        logic        start_before;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int m_addr, m_count;
    logic m_err, m_done, m_full;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [32:0] model(input vec_t v);
        int unsigned w;
        logic ok;
        ok = 1'b1;
        w = 32'(v.op) * 32'h0400_0000;
        if (v.op == 6'd0)
            w += 32'(v.rs) * 2097152 + 32'(v.rt) * 65536 + 32'(v.rd) * 2048 + 32'(v.sh) * 64 + 32'(v.fn);
        else if (v.op == 6'd8 || v.op == 6'd35 || v.op == 6'd43 || v.op == 6'd4)
            w += 32'(v.rs) * 2097152 + 32'(v.rt) * 65536 + 32'(v.imm);
        else if (v.op == 6'd2)
            w += 32'(v.tgt);
        else
            ok = 1'b0;
        return {ok, w};
    endfunction

    task automatic model_clear();
        m_addr = 0; m_count = 0; m_err = 1'b0; m_done = 1'b0; m_full = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_err"}, 32'(err_illegal), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_clear();
        chk("start_count", 32'(count), 32'd0);
        chk("start_addr", 32'(mem_addr), 32'd0);
        chk("start_flags", {29'd0, done, full, err_illegal}, 32'd0);
        chk("start_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        tick();
        model_clear();
    endtask

    task automatic set_fields(input vec_t v);
        opcode = v.op; rs = v.rs; rt = v.rt; rd = v.rd; shamt = v.sh;
        funct = v.fn; imm = v.imm; target = v.tgt; last = v.last;
    endtask

    task automatic offer(input vec_t v);
        set_fields(v);
        chk("ready_before_offer", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic xact(input vec_t v, input logic legal, input logic [31:0] word, input int wait_n);
        logic stop;
        offer(v);
        if (legal) begin
            chk("we_first", 32'(mem_we), 32'd1);
            chk("addr", 32'(mem_addr), 32'(m_addr));
            chk("wdata", mem_wdata, word);
            chk("ready_in_write", 32'(in_ready), 32'd0);
            for (int k = 0; k < wait_n; k++) begin
                tick();
                chk("hold_we", 32'(mem_we), 32'd1);
                chk("hold_addr", 32'(mem_addr), 32'(m_addr));
                chk("hold_wdata", mem_wdata, word);
                chk("hold_ready", 32'(in_ready), 32'd0);
                chk("hold_count", 32'(count), 32'(m_count));
            end
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            stop = v.last || m_addr == 255;
            m_full = m_addr == 255;
            m_count++;
            if (m_addr < 255) m_addr++;
            m_done = stop;
            chk("we_after_ack", 32'(mem_we), 32'd0);
            chk("count", 32'(count), 32'(m_count));
            chk("addr_after_ack", 32'(mem_addr), 32'(m_addr));
            chk("done", 32'(done), 32'(m_done));
            chk("full", 32'(full), 32'(m_full));
            chk("ready_after_ack", 32'(in_ready), 32'(!m_done));
        end else begin
            m_err = 1'b1;
            chk("illegal_we", 32'(mem_we), 32'd0);
            chk("illegal_addr", 32'(mem_addr), 32'(m_addr));
            chk("illegal_ready", 32'(in_ready), 32'd1);
        end
        chk("err", 32'(err_illegal), 32'(m_err));
    endtask

    initial begin
        vec_t v;
        logic [32:0] m;
        int r;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ack = 1'b0;
        opcode = '0; rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0;
        imm = '0; target = '0; last = 1'b0;
        tbl[0] = '{6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 26'h0, 1'b1, 1'b1, 32'h00221820, 1'b1};
        tbl[1] = '{6'h23, 5'd0, 5'd8, 5'h1f, 5'h1f, 6'h3f, 16'h0004, 26'h3ffffff, 1'b0, 1'b1, 32'h8C080004, 1'b1};
        tbl[2] = '{6'h2b, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0008, 26'h0, 1'b0, 1'b1, 32'hAC080008, 1'b0};
        tbl[3] = '{6'h02, 5'h1f, 5'h1f, 5'h1f, 5'h1f, 6'h3f, 16'hffff, 26'h10, 1'b1, 1'b1, 32'h08000010, 1'b0};
        tbl[4] = '{6'h3f, 5'd1, 5'd2, 5'd3, 5'd4, 6'h05, 16'h0006, 26'h7, 1'b0, 1'b0, 32'h0, 1'b1};
        tbl[5] = '{6'h08, 5'd0, 5'd9, 5'd0, 5'd0, 6'h00, 16'hFFFF, 26'h0, 1'b0, 1'b1, 32'h2009FFFF, 1'b0};
        tbl[6] = '{6'h01, 5'd7, 5'd7, 5'd7, 5'd7, 6'h07, 16'h0007, 26'h7, 1'b1, 1'b0, 32'h0, 1'b0};
        tbl[7] = '{6'h04, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0003, 26'h0, 1'b1, 1'b1, 32'h10220003, 1'b0};
        #12;
        check_reset_values("reset");
        reset = 1'b0;
        tick();
        model_clear();
        check_reset_values("post_reset");

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].start_before) do_start();
            xact(tbl[i], tbl[i].legal, tbl[i].word, 0);
        end

        do_start();
        v = '{6'h08, 5'd3, 5'd4, 5'd0, 5'd0, 6'h00, 16'h1234, 26'h0, 1'b0, 1'b1, 32'h20641234, 1'b0};
        xact(v, 1'b1, 32'h20641234, 4);

        do_start();
        set_fields(v);
        start = 1'b1; in_valid = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b0;
        chk("start_wins_we", 32'(mem_we), 32'd0);
        chk("start_wins_ready", 32'(in_ready), 32'd1);
        chk("start_wins_count", 32'(count), 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("idle_ack_count", 32'(count), 32'd0);
        chk("idle_ack_addr", 32'(mem_addr), 32'd0);

        pulse_reset();
        do_start();
        for (int i = 0; i < 4; i++) begin
            v = '{6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'(i), 26'h0, 1'b0, 1'b1, 32'h0, 1'b0};
            offer(v);
            chk("full_we", 32'(mem_we2), 32'd1);
            chk("full_addr", 32'(mem_addr2), 32'(i));
            chk("full_wdata", mem_wdata2, 32'h20220000 + 32'(i));
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            chk("full_count", 32'(count2), 32'(i + 1));
            chk("full_flag", 32'(full2), 32'(i == 3));
            chk("full_done", 32'(done2), 32'(i == 3));
        end
        chk("full_ready", 32'(in_ready2), 32'd0);
        chk("full_addr_held", 32'(mem_addr2), 32'd3);
        offer(v);
        chk("done_no_accept_we", 32'(mem_we2), 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("done_no_accept_count", 32'(count2), 32'd4);
        chk("done_held", 32'(done2), 32'd1);
        do_start();
        chk("full_cleared", {30'd0, full2, done2}, 32'd0);
        chk("full_restart_count", 32'(count2), 32'd0);
        offer(v);
        chk("restart_addr", 32'(mem_addr2), 32'd0);
        chk("restart_we", 32'(mem_we2), 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;

        pulse_reset();
        v = '{6'h00, 5'd4, 5'd5, 5'd6, 5'd1, 6'h2a, 16'h0, 26'h0, 1'b0, 1'b1, 32'h0, 1'b0};
        offer(v);
        chk("pre_reset_we", 32'(mem_we), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        #2;
        reset = 1'b0;
        tick();
        model_clear();
        m = model(v);
        xact(v, m[32], m[31:0], 1);

        do_start();
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 7);
            v.op = r == 0 ? 6'h00 : r == 1 ? 6'h08 : r == 2 ? 6'h23 : r == 3 ? 6'h2b
                 : r == 4 ? 6'h04 : r == 5 ? 6'h02 : r == 6 ? 6'($urandom) : 6'h3f;
            v.rs = 5'($urandom); v.rt = 5'($urandom); v.rd = 5'($urandom);
            v.sh = 5'($urandom); v.fn = 6'($urandom); v.imm = 16'($urandom);
            v.tgt = 26'($urandom);
            v.last = $urandom_range(0, 15) == 0;
            m = model(v);
            xact(v, m[32], m[31:0], $urandom_range(0, 3));
            if (m_done) do_start();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
